// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter (8N1) fed by a small byte FIFO. Bytes written with `start`
// are queued. Whenever the serialiser is idle and the queue is non-empty, the
// head byte is popped on the next rising edge and a frame is sent:
//   - one start bit (0),
//   - eight data bits, LSB first,
//   - one stop bit (1).
// Each bit lasts CLKCOUNTER clock cycles. Back-to-back frames are separated by
// exactly one idle-high cycle, which is the IDLE state in which `done` pulses.
//
// Parameters
//   CLKCOUNTER     clock cycles per serial bit period
//   NBITS_COUNTER  width of the bit-period counter (must hold CLKCOUNTER-1)
//   FIFO_DEPTH     transmit queue entries (power of two, >= 2)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   dataTX    in   byte to enqueue, sampled while start is high
//   start     in   enqueue strobe; one byte per cycle it is high
//   serialTX  out  UART line, idles high
//   busy      out  frame in progress, completion cycle, or bytes queued
//   full      out  queue holds FIFO_DEPTH bytes; writes are dropped
//   done      out  one-cycle pulse in the first IDLE cycle after a stop bit
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKCOUNTER    = 10_417,
    parameter int NBITS_COUNTER = 14,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dataTX,
    input  logic       start,
    output logic       serialTX,
    output logic       busy,
    output logic       full,
    output logic       done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [NBITS_COUNTER-1:0] BIT_LAST   = NBITS_COUNTER'(CLKCOUNTER - 1);
    localparam logic [CNT_W-1:0]         COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]         PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Transmit queue
    // -------------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // -------------------------------------------------------------------------
    // Serialiser
    // -------------------------------------------------------------------------
    state_t                   r_state;
    logic [NBITS_COUNTER-1:0] r_bit_cnt;
    logic [2:0]               r_bit_idx;
    logic [7:0]               r_shift;
    logic                     r_serial;
    logic                     r_done;

    logic w_fifo_empty;
    logic w_push;
    logic w_pop;
    logic w_bit_end;

    assign w_fifo_empty = (r_count == '0);
    assign full         = (r_count == COUNT_FULL);

    // A write while full is dropped even if a pop happens on the same edge;
    // the decision is made from the registered count only.
    assign w_push    = start && !full;
    assign w_pop     = (r_state == IDLE) && !w_fifo_empty;
    assign w_bit_end = (r_bit_cnt == BIT_LAST);

    // -------------------------------------------------------------------------
    // Queue storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array is deliberately left out of reset; emptiness is
    // tracked by r_count, so stale entries are never read and the array can map
    // onto plain RAM/LUT-RAM without a reset network.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dataTX;
        end
    end

    // -------------------------------------------------------------------------
    // Queue pointers and occupancy
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM
    //
    // The bit counter restarts on every bit boundary and on every state entry,
    // so each bit (start, data, stop) lasts exactly CLKCOUNTER cycles. The byte
    // is copied into r_shift at the pop edge, so later changes on dataTX or in
    // the queue cannot disturb the frame in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the STOP exit raises it.
            r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_bit_idx <= '0;
                    r_serial  <= 1'b1;
                    if (w_pop) begin
                        r_shift  <= r_mem[r_rd_ptr];
                        r_serial <= 1'b0;
                        r_state  <= START;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_serial  <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_state   <= DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_serial <= 1'b1;
                            r_state  <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_serial  <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= '0;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_serial <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all taken from registered state, nothing combinational from
    // start/dataTX reaches a port. The completion cycle still counts as busy,
    // so busy drops the cycle after the final done pulse.
    // -------------------------------------------------------------------------
    assign serialTX = r_serial;
    assign done     = r_done;
    assign busy     = (r_state != IDLE) || !w_fifo_empty || r_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo with CLKCOUNTER=4, FIFO_DEPTH=4. Stimulus pushes every
// byte it expects on the line into sb_q; an independent monitor decodes the
// serial line cycle by cycle, pops the expected byte when a start bit appears
// and compares each bit period, the done pulse and the inter-frame gap.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CLKC  = 4;
    localparam int NBC   = 2;
    localparam int DEPTH = 4;
    localparam int FRAME_CYCLES = 10 * CLKC + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dataTX;
    logic       start;
    logic       serialTX;
    logic       busy;
    logic       full;
    logic       done;

    int n_checks    = 0;
    int n_fail      = 0;
    int frames_done = 0;
    int done_seen   = 0;
    bit gap_check_en = 1'b0;

    logic [7:0] sb_q [$];

    logic [7:0] wrap_vec [10] = '{8'h0F, 8'h2C, 8'h49, 8'h66, 8'h83,
                                  8'hA0, 8'hBD, 8'hDA, 8'hF7, 8'h14};

    uart_tx_fifo #(
        .CLKCOUNTER    (CLKC),
        .NBITS_COUNTER (NBC),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dataTX   (dataTX),
        .start    (start),
        .serialTX (serialTX),
        .busy     (busy),
        .full     (full),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Drive one write; returns 1 time unit after the sampling edge.
    task automatic write_byte(input logic [7:0] b, input bit accept);
        dataTX = b;
        start  = 1'b1;
        if (accept) sb_q.push_back(b);
        @(posedge clk);
        #1;
        start  = 1'b0;
        dataTX = ~b;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frames_within_budget", frames_done >= target, 1);
    endtask

    task automatic wait_done_negedge(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < budget);
        check("done_seen_within_budget", done, 1);
    endtask

    task automatic wait_fall(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (serialTX !== 1'b0 && n < budget);
        check("start_bit_within_budget", serialTX, 0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) done_seen++;
    end

    // -------------------------------------------------------------------------
    // Line monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin : monitor
        int         gap;
        bit         more_pending;
        bit         aborted;
        bit         bit_ok;
        bit         done_low;
        logic       exp_bit;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        gap = 0;
        more_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                gap = 0;
                more_pending = 1'b0;
            end else if (serialTX !== 1'b0) begin
                gap++;
            end else begin
                if (gap_check_en && more_pending) check("idle_gap_cycles", gap, 1);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: actual=start bit on line required=idle line");
                    exp_b = 8'h00;
                end else begin
                    exp_b = sb_q.pop_front();
                end
                got_b    = '0;
                aborted  = 1'b0;
                done_low = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    if (b == 0)      exp_bit = 1'b0;
                    else if (b == 9) exp_bit = 1'b1;
                    else             exp_bit = exp_b[b-1];
                    bit_ok = 1'b1;
                    for (int s = 0; s < CLKC; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (rst !== 1'b0) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (serialTX !== exp_bit) bit_ok = 1'b0;
                        if (done !== 1'b0) done_low = 1'b0;
                        if (s == CLKC / 2 && b >= 1 && b <= 8) got_b[b-1] = serialTX;
                    end
                    if (aborted) break;
                    check($sformatf("frame_%02h_bit%0d", exp_b, b), bit_ok, 1);
                end
                if (aborted) begin
                    gap = 0;
                    more_pending = 1'b0;
                end else begin
                    check("frame_byte", got_b, exp_b);
                    check("done_low_during_frame", done_low, 1);
                    @(negedge clk);
                    check("done_after_stop", done, 1);
                    check("line_high_in_done_cycle", serialTX, 1);
                    frames_done++;
                    gap = 1;
                    more_pending = (sb_q.size() > 0);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : stimulus
        int done_before;
        rst    = 1'b1;
        start  = 1'b0;
        dataTX = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_serialTX", serialTX, 1);
        check("reset_busy", busy, 0);
        check("reset_full", full, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        // Single byte 0xA5: latency, bit pattern, done position
        write_byte(8'hA5, 1'b1);
        check("a5_line_high_after_write_edge", serialTX, 1);
        check("a5_busy_after_write_edge", busy, 1);
        @(posedge clk);
        #1;
        check("a5_start_bit_after_next_edge", serialTX, 0);
        wait_frames(1, 2 * FRAME_CYCLES);
        check("a5_single_done", done_seen, 1);
        check("a5_busy_after_done", busy, 0);

        // Six consecutive writes from empty: fifth fills, sixth dropped
        gap_check_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            write_byte(8'(i), i <= 5);
            check($sformatf("burst_full_after_write%0d", i), full, (i >= 5));
        end
        check("burst_busy", busy, 1);
        wait_frames(6, 6 * FRAME_CYCLES);
        check("burst_busy_after_last_done", busy, 0);

        // Push on the pop edge with two bytes queued; occupancy must stay 2,
        // so exactly two more writes fill the queue.
        write_byte(8'h81, 1'b1);
        write_byte(8'h42, 1'b1);
        write_byte(8'hC3, 1'b1);
        wait_done_negedge(2 * FRAME_CYCLES);
        dataTX = 8'hD4;
        start  = 1'b1;
        sb_q.push_back(8'hD4);
        @(posedge clk);
        #1;
        start  = 1'b0;
        dataTX = 8'h00;
        check("poppush_full_after_same_edge", full, 0);
        write_byte(8'hE5, 1'b1);
        check("popush_full_third", full, 0);
        write_byte(8'hF6, 1'b1);
        check("popush_full_fourth", full, 1);
        write_byte(8'h99, 1'b0);
        check("popush_full_after_drop", full, 1);
        wait_frames(12, 8 * FRAME_CYCLES);
        check("popush_busy_after_done", busy, 0);

        // Reset during data bit 3 with two bytes queued
        gap_check_en = 1'b0;
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        wait_fall(20);
        repeat (16) @(negedge clk);   // lands inside data bit 3
        done_before = done_seen;
        #1;
        rst = 1'b1;
        #1;
        check("midframe_rst_serialTX", serialTX, 1);
        check("midframe_rst_busy", busy, 0);
        check("midframe_rst_full", full, 0);
        check("midframe_rst_done", done, 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("midframe_rst_no_done", done_seen, done_before);
        write_byte(8'h3C, 1'b1);     // sampled on first edge after release
        @(posedge clk);
        #1;
        check("post_rst_start_bit", serialTX, 0);
        wait_frames(13, 2 * FRAME_CYCLES);

        // Pointer wrap: ten writes, each after the previous frame completed
        for (int i = 0; i < 10; i++) begin
            write_byte(wrap_vec[i], 1'b1);
            check($sformatf("wrap_full_after_write%0d", i), full, 0);
            wait_frames(14 + i, 2 * FRAME_CYCLES);
        end

        repeat (4) @(posedge clk);
        #1;
        check("done_pulses_match_frames", done_seen, frames_done);
        check("scoreboard_drained", sb_q.size(), 0);
        check("final_line_idle", serialTX, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKCOUNTER, default 10_417: clock cycles per serial bit period.
REQ-002 Parameter NBITS_COUNTER, default 14: width of the bit-period counter; SHALL hold CLKCOUNTER-1.
REQ-003 Parameter FIFO_DEPTH, default 4: byte entries in the transmit buffer; power of two.
REQ-004 Port clk, input, 1: single system clock, all logic on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port dataTX, input, 8: byte to enqueue, sampled when start is high.
REQ-007 Port start, input, 1: enqueue strobe, one byte per cycle high.
REQ-008 Port serialTX, output, 1: UART line, idle high.
REQ-009 Port busy, output, 1: high while a frame is in progress or FIFO is non-empty.
REQ-010 Port full, output, 1: high when FIFO holds FIFO_DEPTH entries.
REQ-011 Port done, output, 1: one-cycle pulse after each completed stop bit.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1; each bit held exactly CLKCOUNTER cycles; frame = 10*CLKCOUNTER cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE with FIFO non-empty: next edge pops head into shift register, enters START, drives serialTX low.
REQ-015 START -> DATA after CLKCOUNTER cycles; DATA -> STOP after 8 bit periods (3-bit bit index 0..7); STOP -> IDLE after CLKCOUNTER cycles.
REQ-016 Bit counter SHALL count 0..CLKCOUNTER-1, clear on every bit boundary and on every state entry.
REQ-017 done SHALL be high for exactly the first cycle in IDLE following STOP, low otherwise.
REQ-018 Back-to-back frames SHALL be separated by exactly one clk cycle of serialTX high (the IDLE cycle).
REQ-019 start sampled high with full low SHALL write dataTX at the tail; with full high the byte SHALL be dropped, pointers and count unchanged.
REQ-020 Push and pop on the same edge (full low) SHALL leave count unchanged and store the byte correctly.
REQ-021 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-022 Latency: byte written at edge k into an empty FIFO with FSM in IDLE SHALL drive serialTX low after edge k+1.
REQ-023 full and busy SHALL be registered or derived only from registered state; no combinational path from start to any output.
REQ-024 dataTX changes after the pop edge SHALL NOT affect the frame in progress.

Reset
REQ-025 rst high SHALL immediately set serialTX=1, busy=0, full=0, done=0, FSM=IDLE, counters and pointers zero, FIFO empty, independent of clk.
REQ-026 Reset mid-frame SHALL abort the frame with no done pulse and discard all queued bytes.
REQ-027 First edge after rst deasserts SHALL accept a start write normally.

Verification (CLKCOUNTER=4, FIFO_DEPTH=4 unless stated)
REQ-028 Write 0xA5 once -> serialTX low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; done pulses once, 40 cycles after the falling edge.
REQ-029 Six writes 0x01..0x06 on consecutive edges from empty -> full high after the fifth write, 0x06 dropped, frames 0x01..0x05 sent in order, each separated by exactly one high cycle; busy falls the cycle after the fifth done.
REQ-030 Write issued on the same edge as a pop with count=2 -> count stays 2; byte order preserved on the line.
REQ-031 Assert rst during data bit 3 with 2 bytes queued -> serialTX=1 in the same cycle, busy=0, no done; a later write of 0x3C transmits a clean 0x3C frame.
REQ-032 Pointer wrap: 10 single writes, each issued after the previous done -> all 10 bytes correct, full never asserts.
REQ-033 Defaults (CLKCOUNTER=10_417) looped into the team's UART receiver -> 0x00, 0xFF, 0x55 received intact, one receiver done per byte.
